// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - parametrised packed-BCD modulo-N up/down counter with wrap pulses and terminal count
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  borrow,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  if (MODULUS < 2 || longint'(MODULUS) > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS out of range for DIGITS");
  end

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // With every digit <= 9, unsigned order of the packed vector equals numeric order.
  logic load_ok, count_ok;
  assign load_ok  = digits_ok(load_val) && (load_val <= MAX_BCD);
  assign count_ok = digits_ok(count) && (count <= MAX_BCD);

  assign tc = up_dn ? (count == MAX_BCD) : (count == '0);

  logic [W-1:0] inc_val, dec_val;
  logic         inc_c, dec_b;

  always_comb begin
    inc_val = '0;
    dec_val = '0;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!inc_c)                     inc_val[4*i +: 4] = count[4*i +: 4];
      else if (count[4*i +: 4] == 4'd9) inc_val[4*i +: 4] = 4'd0;
      else begin
        inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
        inc_c             = 1'b0;
      end
      if (!dec_b)                     dec_val[4*i +: 4] = count[4*i +: 4];
      else if (count[4*i +: 4] == 4'd0) dec_val[4*i +: 4] = 4'd9;
      else begin
        dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
        dec_b             = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        if (load_ok) count    <= load_val;
        else         load_err <= 1'b1;
      end else if (en) begin
        // An upset count recovers to zero silently rather than wrapping.
        if (!count_ok) begin
          count <= '0;
        end else if (up_dn) begin
          if (count == MAX_BCD) begin
            count <= '0;
            carry <= 1'b1;
          end else begin
            count <= inc_val;
          end
        end else begin
          if (count == '0) begin
            count  <= MAX_BCD;
            borrow <= 1'b1;
          end else begin
            count <= dec_val;
          end
        end
      end
    end
  end

endmodule
